cache_pmem_arbiter: RTL

- Shares the single physical-memory cacheline port between the instruction cache and the data cache of the pipelined rv32i core.
- Sits between both caches and the cacheline adaptor.
- Grants one requester at a time, steers its command/data to memory, and routes the response back.
- Uses round-robin fairness so neither fetch nor load/store traffic starves.
- Keeps saturating grant counters for performance analysis.

---
 rtl/cache_pmem_arbiter.sv | 105 ++++++++++
 1 files changed

// File: rtl/cache_pmem_arbiter.sv
// Round-robin arbiter sharing one physical-memory cacheline port between
// the instruction cache and the data cache, with saturating grant counters.
module cache_pmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned LINE_WIDTH = 256,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  mem_read,
  output logic                  mem_write,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic [LINE_WIDTH-1:0] mem_wdata,
  input  logic [LINE_WIDTH-1:0] mem_rdata,
  input  logic                  mem_resp,
  output logic [CNT_WIDTH-1:0]  i_grant_cnt,
  output logic [CNT_WIDTH-1:0]  d_grant_cnt
);

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D, DONE} state_t;

  state_t               r_state;
  state_t               w_next;
  logic                 r_last_d;
  logic [CNT_WIDTH-1:0] r_i_cnt;
  logic [CNT_WIDTH-1:0] r_d_cnt;
  logic                 w_req_i;
  logic                 w_req_d;
  logic                 w_grant_i;
  logic                 w_grant_d;

  assign w_req_i   = i_read;
  assign w_req_d   = d_read | d_write;
  // When both request, the side not served last wins.
  assign w_grant_d = w_req_d & (~w_req_i | ~r_last_d);
  assign w_grant_i = w_req_i & ~w_grant_d;

  assign i_rdata     = mem_rdata;
  assign d_rdata     = mem_rdata;
  assign i_grant_cnt = r_i_cnt;
  assign d_grant_cnt = r_d_cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_last_d <= 1'b0;
      r_i_cnt  <= '0;
      r_d_cnt  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_grant_d)      r_last_d <= 1'b1;
        else if (w_grant_i) r_last_d <= 1'b0;
      end
      if (r_state == SERVE_I && mem_resp && r_i_cnt != '1)
        r_i_cnt <= r_i_cnt + CNT_WIDTH'(1);
      if (r_state == SERVE_D && mem_resp && r_d_cnt != '1)
        r_d_cnt <= r_d_cnt + CNT_WIDTH'(1);
    end
  end

  always_comb begin
    w_next      = r_state;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_address = '0;
    mem_wdata   = '0;
    i_resp      = 1'b0;
    d_resp      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_grant_d)      w_next = SERVE_D;
        else if (w_grant_i) w_next = SERVE_I;
      end
      SERVE_I: begin
        mem_read    = 1'b1;
        mem_address = i_address;
        i_resp      = mem_resp;
        if (mem_resp) w_next = DONE;
      end
      SERVE_D: begin
        // A simultaneous read and write issues only the writeback.
        mem_read    = d_read & ~d_write;
        mem_write   = d_write;
        mem_address = d_address;
        mem_wdata   = d_wdata;
        d_resp      = mem_resp;
        if (mem_resp) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

endmodule
